// File: rtl/systolic_tile_engine.sv
// Output-stationary ROWS x COLS systolic MAC tile: skews operand beats into the
// array, accumulates over a K stream, then drains one row per handshake.
module systolic_tile_engine #(
  parameter int unsigned ROWS = 8,
  parameter int unsigned COLS = 8,
  parameter int unsigned DW   = 8,
  parameter int unsigned AW   = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ROWS*DW-1:0]           in_a,
  input  logic [COLS*DW-1:0]           in_w,
  input  logic                         in_last,
  input  logic                         signed_mode,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [COLS*AW-1:0]           out_data,
  output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] out_row,
  output logic                         out_last,
  output logic                         busy
);

  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned F  = ROWS + COLS - 1;
  localparam int unsigned CW = $clog2(F + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DRAIN} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [RW-1:0]   row_nxt;
  logic            smode;
  logic            accept;
  logic            clr;

  assign accept = in_valid & in_ready;

  // Next-state logic; accumulators clear on the first beat of a tile
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    row_nxt   = out_row;
    clr       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          clr       = 1'b1;
          cnt_nxt   = '0;
          state_nxt = in_last ? S_FLUSH : S_LOAD;
        end
      end
      S_LOAD: begin
        if (accept && in_last) begin
          cnt_nxt   = '0;
          state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (cnt == CW'(F - 1)) begin
          state_nxt = S_DRAIN;
          row_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (out_row == RW'(ROWS - 1)) begin
            state_nxt = S_IDLE;
            row_nxt   = '0;
          end else begin
            row_nxt = out_row + RW'(1);
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      out_row   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      smode     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      out_row   <= row_nxt;
      in_ready  <= (state_nxt == S_IDLE) || (state_nxt == S_LOAD);
      out_valid <= (state_nxt == S_DRAIN);
      out_last  <= (state_nxt == S_DRAIN) && (row_nxt == RW'(ROWS - 1));
      busy      <= (state_nxt != S_IDLE);
      if (state == S_IDLE && accept) smode <= signed_mode;
    end
  end

  // Input skew: row r activation delayed r cycles, column c weight delayed c cycles
  logic [ROWS*DW-1:0] edge_a;
  logic [ROWS-1:0]    edge_av;
  logic [COLS*DW-1:0] edge_w;
  logic [COLS-1:0]    edge_wv;

  for (genvar g = 0; g < ROWS; g++) begin : g_askew
    if (g == 0) begin : g_direct
      assign edge_a[DW-1:0] = in_a[DW-1:0];
      assign edge_av[0]     = accept;
    end else begin : g_delay
      logic [DW-1:0] d [g];
      logic [g-1:0]  v;
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < g; i++) d[i] <= '0;
          v <= '0;
        end else begin
          d[0] <= in_a[g*DW +: DW];
          v[0] <= accept;
          for (int i = 1; i < g; i++) begin
            d[i] <= d[i-1];
            v[i] <= v[i-1];
          end
        end
      end
      assign edge_a[g*DW +: DW] = d[g-1];
      assign edge_av[g]         = v[g-1];
    end
  end

  for (genvar g = 0; g < COLS; g++) begin : g_wskew
    if (g == 0) begin : g_direct
      assign edge_w[DW-1:0] = in_w[DW-1:0];
      assign edge_wv[0]     = accept;
    end else begin : g_delay
      logic [DW-1:0] d [g];
      logic [g-1:0]  v;
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < g; i++) d[i] <= '0;
          v <= '0;
        end else begin
          d[0] <= in_w[g*DW +: DW];
          v[0] <= accept;
          for (int i = 1; i < g; i++) begin
            d[i] <= d[i-1];
            v[i] <= v[i-1];
          end
        end
      end
      assign edge_w[g*DW +: DW] = d[g-1];
      assign edge_wv[g]         = v[g-1];
    end
  end

  function automatic logic [AW-1:0] mac_prod(input logic [DW-1:0] a,
                                             input logic [DW-1:0] w,
                                             input logic          sm);
    logic [AW-1:0] ea, ew;
    if (sm) begin
      ea = AW'($signed(a));
      ew = AW'($signed(w));
    end else begin
      ea = AW'(a);
      ew = AW'(w);
    end
    return ea * ew;
  endfunction

  // PE grid: activations move right, weights move down, MAC only when both tags set
  logic [DW-1:0] pa  [ROWS][COLS];
  logic          pav [ROWS][COLS];
  logic [DW-1:0] pw  [ROWS][COLS];
  logic          pwv [ROWS][COLS];
  logic [AW-1:0] acc [ROWS][COLS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          pa[r][c]  <= '0;
          pav[r][c] <= 1'b0;
          pw[r][c]  <= '0;
          pwv[r][c] <= 1'b0;
          acc[r][c] <= '0;
        end
      end
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        pa[r][0]  <= edge_a[r*DW +: DW];
        pav[r][0] <= edge_av[r];
        for (int c = 1; c < COLS; c++) begin
          pa[r][c]  <= pa[r][c-1];
          pav[r][c] <= pav[r][c-1];
        end
      end
      for (int c = 0; c < COLS; c++) begin
        pw[0][c]  <= edge_w[c*DW +: DW];
        pwv[0][c] <= edge_wv[c];
        for (int r = 1; r < ROWS; r++) begin
          pw[r][c]  <= pw[r-1][c];
          pwv[r][c] <= pwv[r-1][c];
        end
      end
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          if (clr) begin
            acc[r][c] <= '0;
          end else if (pav[r][c] && pwv[r][c]) begin
            acc[r][c] <= acc[r][c] + mac_prod(pa[r][c], pw[r][c], smode);
          end
        end
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int c = 0; c < COLS; c++) out_data[c*AW +: AW] = acc[out_row][c];
  end

endmodule

// File: tb/tb_systolic_tile_engine.sv
// Scoreboard bench for systolic_tile_engine: a 32-bit and a 16-bit accumulator
// instance share stimulus; a behavioural model predicts every drained row.
module tb_systolic_tile_engine;

  localparam int unsigned ROWS = 8;
  localparam int unsigned COLS = 8;
  localparam int unsigned DW   = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_last, signed_mode, out_ready;
  logic [63:0]   in_a, in_w;
  logic          in_ready, out_valid, out_last, busy;
  logic [255:0]  out_data;
  logic [2:0]    out_row;
  logic          in_ready16, out_valid16, out_last16, busy16;
  logic [127:0]  out_data16;
  logic [2:0]    out_row16;

  systolic_tile_engine #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .AW(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_w(in_w), .in_last(in_last), .signed_mode(signed_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_last(out_last), .busy(busy));

  systolic_tile_engine #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .AW(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
    .in_a(in_a), .in_w(in_w), .in_last(in_last), .signed_mode(signed_mode),
    .out_valid(out_valid16), .out_ready(out_ready), .out_data(out_data16),
    .out_row(out_row16), .out_last(out_last16), .busy(busy16));

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   row;
    logic         last;
    logic [255:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [63:0] ta[$];
  logic [63:0] tw[$];
  int          checks = 0;
  int          failures = 0;
  bit          rand_ready = 1'b0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ext8(input logic [7:0] v, input logic sm);
    if (sm) return {{24{v[7]}}, v};
    return {24'd0, v};
  endfunction

  function automatic logic [255:0] lo16(input logic [255:0] d);
    logic [255:0] r;
    r = '0;
    for (int c = 0; c < COLS; c++) r[c*16 +: 16] = d[c*32 +: 16];
    return r;
  endfunction

  // Model of one tile from the beat queues; pushes one expected entry per row
  task automatic push_tile(input logic sm);
    exp_t        e;
    logic [31:0] s;
    for (int r = 0; r < ROWS; r++) begin
      e.row  = 3'(r);
      e.last = (r == ROWS - 1);
      e.data = '0;
      for (int c = 0; c < COLS; c++) begin
        s = 32'd0;
        for (int k = 0; k < ta.size(); k++)
          s = s + ext8(ta[k][r*8 +: 8], sm) * ext8(tw[k][c*8 +: 8], sm);
        e.data[c*32 +: 32] = s;
      end
      sb.push_back(e);
    end
  endtask

  // Scoreboard monitor: every valid cycle must match the head entry
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_row", 1, 0);
      end else begin
        mon_e = sb[0];
        check("out_row", out_row, mon_e.row);
        check("out_last", out_last, mon_e.last);
        check("out_data", out_data, mon_e.data);
        check("out_row16", out_row16, mon_e.row);
        check("out_last16", out_last16, mon_e.last);
        check("out_data16", out_data16, lo16(mon_e.data));
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    #1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic drive_beat(input logic [63:0] a, input logic [63:0] w,
                            input logic last, input logic sm_drive);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_a = a;
    in_w = w;
    in_last = last;
    signed_mode = sm_drive;
    for (int n = 0; n < 500 && !done; n++) begin
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) check("accept_timeout", 0, 1);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 5000 && sb.size() > 0; n++) begin
      @(posedge clk);
      #1;
    end
    if (sb.size() > 0) begin
      check("drain_timeout", 256'(sb.size()), 0);
      sb.delete();
    end
  endtask

  // Drive a whole tile; signed_mode is flipped after the first beat to prove it is latched
  task automatic run_tile(input logic sm, input int gap, input bit lat_chk, input bit offer);
    bit stop;
    push_tile(sm);
    for (int k = 0; k < ta.size(); k++) begin
      drive_beat(ta[k], tw[k], k == ta.size() - 1, (k == 0) ? sm : ~sm);
      if (gap > 0 && k != ta.size() - 1) repeat (gap) begin @(posedge clk); #1; end
    end
    if (lat_chk) begin
      repeat (14) @(posedge clk);
      #1;
      check("valid_before_F", out_valid, 0);
      check("busy_flush", busy, 1);
      check("in_ready_flush", in_ready, 0);
      @(posedge clk);
      #1;
      check("valid_at_F", out_valid, 1);
    end
    if (offer) begin
      stop = 1'b0;
      for (int n = 0; n < 5000 && !stop; n++) begin
        if (out_valid) begin
          in_valid = 1'b1;
          in_a = 64'hA5A5_A5A5_A5A5_A5A5;
          in_w = 64'h0303_0303_0303_0303;
          in_last = 1'b1;
          check("in_ready_drain", in_ready, 0);
          check("in_ready16_drain", in_ready16, 0);
        end else begin
          in_valid = 1'b0;
          in_last = 1'b0;
          if (sb.size() == 0) stop = 1'b1;
        end
        if (!stop) begin
          @(posedge clk);
          #1;
        end
      end
      check("in_ready_after", in_ready, 1);
      check("busy_after", busy, 0);
    end
    wait_drain();
  endtask

  task automatic check_reset();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_row", out_row, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready16", in_ready16, 1);
    check("rst_busy16", busy16, 0);
    check("rst_out_data16", out_data16, 0);
  endtask

  task automatic fill_const(input int k, input logic [7:0] a, input logic [7:0] w);
    ta.delete();
    tw.delete();
    for (int i = 0; i < k; i++) begin
      ta.push_back({8{a}});
      tw.push_back({8{w}});
    end
  endtask

  initial begin
    logic [63:0] av, wv;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; signed_mode = 1'b0;
    in_a = '0; in_w = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset mid-LOAD: partial tile must leave no trace
    for (int k = 0; k < 3; k++) drive_beat({8{8'h77}}, {8{8'h11}}, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Unsigned ramp, K=10, w=1: every word 55, latency F=15
    ta.delete();
    tw.delete();
    for (int k = 1; k <= 10; k++) begin
      ta.push_back({8{8'(k)}});
      tw.push_back({8{8'h01}});
    end
    run_tile(1'b0, 0, 1'b1, 1'b0);

    // Signed versus unsigned, K=3, a=0xFF, w=0x02
    fill_const(3, 8'hFF, 8'h02);
    run_tile(1'b1, 0, 1'b0, 1'b0);
    fill_const(3, 8'hFF, 8'h02);
    run_tile(1'b0, 0, 1'b0, 1'b0);

    // Distinct lanes, K=1, then K=4 with a bubble between beats
    for (int i = 0; i < 8; i++) begin
      av[i*8 +: 8] = 8'(i + 1);
      wv[i*8 +: 8] = 8'(i + 1);
    end
    ta.delete(); tw.delete();
    ta.push_back(av); tw.push_back(wv);
    run_tile(1'b0, 0, 1'b0, 1'b0);
    ta.delete(); tw.delete();
    for (int k = 0; k < 4; k++) begin
      ta.push_back(av);
      tw.push_back(wv);
    end
    run_tile(1'b0, 1, 1'b0, 1'b0);

    // Backpressure with random operands and beats offered during DRAIN
    rand_ready = 1'b1;
    ta.delete(); tw.delete();
    for (int k = 0; k < 6; k++) begin
      ta.push_back({$urandom, $urandom});
      tw.push_back({$urandom, $urandom});
    end
    run_tile(1'b1, 0, 1'b0, 1'b1);
    rand_ready = 1'b0;
    @(posedge clk);
    #1;

    // Wrap: 16-bit instance expects 64514, 32-bit instance 130050
    fill_const(2, 8'hFF, 8'hFF);
    run_tile(1'b0, 0, 1'b0, 1'b0);

    // Reset mid-DRAIN discards the rest of the tile
    fill_const(5, 8'h12, 8'h34);
    push_tile(1'b0);
    for (int k = 0; k < 5; k++) drive_beat(ta[k], tw[k], k == 4, 1'b0);
    for (int n = 0; n < 200 && sb.size() > 5; n++) begin
      @(posedge clk);
      #1;
    end
    check("mid_drain_reached", 256'(sb.size() <= 5), 1);
    rst = 1'b1;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    check_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Fresh signed tile after the drain reset
    ta.delete(); tw.delete();
    for (int k = 0; k < 3; k++) begin
      ta.push_back({$urandom, $urandom});
      tw.push_back({$urandom, $urandom});
    end
    run_tile(1'b1, 0, 1'b0, 1'b0);

    check("sb_empty", 256'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
